// File: rtl/digit_scan_if.sv
// digit_scan_if: display data in, multiplexed 7-segment drive out.
interface digit_scan_if;
  logic        en;
  logic [23:0] digits;
  logic [5:0]  dp_mask;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [5:0]  an_n;
  logic [2:0]  digit_idx;
  logic        frame_tick;
  modport master (output en, digits, dp_mask, input seg_n, dp_n, an_n, digit_idx, frame_tick);
  modport slave  (input en, digits, dp_mask, output seg_n, dp_n, an_n, digit_idx, frame_tick);
endinterface

// File: rtl/digit_scan_demux.sv
// digit_scan_demux: six-digit multiplexed 7-segment scanner with per-frame input snapshot.
// Define GHOST_BLANK_EN to dark the anodes for the first GAP cycles of every slot.
module digit_scan_demux #(
  parameter int DIV = 50000,
  parameter int GAP = 2
) (
  input logic clk,
  input logic rst_n,
  digit_scan_if.slave bus
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  logic [2:0]   idx;
  logic [23:0]  snap_dig;
  logic [5:0]   snap_dp;
  logic [6:0]   seg;
  logic         dp;
  logic [5:0]   an;
  logic         ft;
  logic         slot_end;
  logic         wrap;
  logic         blank;
  logic [3:0]   cur;
  logic [6:0]   dec;
  assign slot_end = bus.en && cnt == W'(DIV - 1);
  assign wrap     = slot_end && idx == 3'd5;
  assign cur      = snap_dig[4*idx +: 4];
`ifdef GHOST_BLANK_EN
  assign blank = cnt < W'(GAP);
`else
  // GAP has no effect in this build; the compare is always false for legal GAP
  assign blank = GAP < 0;
`endif
  always_comb begin
    dec = 7'h7F;
    case (cur)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h7F;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      snap_dig <= '0;
      snap_dp  <= '0;
      ft       <= 1'b0;
      an       <= 6'h3F;
      seg      <= 7'h7F;
      dp       <= 1'b1;
    end else if (bus.en) begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      idx <= slot_end ? (idx == 3'd5 ? 3'd0 : idx + 3'd1) : idx;
      if (wrap) begin
        snap_dig <= bus.digits;
        snap_dp  <= bus.dp_mask;
      end
      ft  <= wrap;
      an  <= blank ? 6'h3F : ~(6'b1 << idx);
      seg <= dec;
      dp  <= ~snap_dp[idx];
    end else begin
      ft  <= 1'b0;
      an  <= 6'h3F;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end
  end
  assign bus.seg_n      = seg;
  assign bus.dp_n       = dp;
  assign bus.an_n       = an;
  assign bus.digit_idx  = idx;
  assign bus.frame_tick = ft;
endmodule

// File: tb/tb_digit_scan_demux.sv
// tb_digit_scan_demux: directed scan, snapshot, blank/dp, enable and reset checks against a cycle model.
module tb_digit_scan_demux;
  localparam int DIV = 4;
  localparam int GAP = 2;
  localparam int FR  = 6 * DIV;
`ifdef GHOST_BLANK_EN
  localparam bit GB = 1'b1;
`else
  localparam bit GB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  digit_scan_if bus ();
  digit_scan_demux #(.DIV(DIV), .GAP(GAP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic [2:0] idx;
    logic       ft;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int t = 0;
  logic [23:0] sdig = '0;
  logic [5:0]  sdp = '0;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask
  task automatic reset_check(input string tag);
    chk({tag, ".an_n"}, 32'(bus.an_n), 32'h3F);
    chk({tag, ".seg_n"}, 32'(bus.seg_n), 32'h7F);
    chk({tag, ".dp_n"}, 32'(bus.dp_n), 32'h1);
    chk({tag, ".digit_idx"}, 32'(bus.digit_idx), 32'h0);
    chk({tag, ".frame_tick"}, 32'(bus.frame_tick), 32'h0);
  endtask
  // one clock: predict the registered outputs, then compare after the edge
  task automatic step();
    exp_t e;
    int c;
    int i;
    if (bus.en) begin
      c = t % DIV;
      i = (t / DIV) % 6;
      e.an  = (GB && c < GAP) ? 6'h3F : ~(6'b1 << i);
      e.seg = seg_of(sdig[4*i +: 4]);
      e.dp  = ~sdp[i];
      e.ft  = (t % FR) == FR - 1;
      if (e.ft) begin
        sdig = bus.digits;
        sdp  = bus.dp_mask;
      end
      t++;
    end else begin
      e.an  = 6'h3F;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.ft  = 1'b0;
    end
    e.idx = 3'((t / DIV) % 6);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    chk("seg_n", 32'(bus.seg_n), 32'(e.seg));
    chk("dp_n", 32'(bus.dp_n), 32'(e.dp));
    chk("an_n", 32'(bus.an_n), 32'(e.an));
    chk("digit_idx", 32'(bus.digit_idx), 32'(e.idx));
    chk("frame_tick", 32'(bus.frame_tick), 32'(e.ft));
  endtask
  task automatic model_reset();
    t = 0;
    sdig = '0;
    sdp = '0;
  endtask
  initial begin
    bus.en = 1'b1;
    bus.digits = 24'h123456;
    bus.dp_mask = 6'b0;
    repeat (3) begin
      @(negedge clk);
      reset_check("hold");
    end
    rst_n = 1'b1;
    model_reset();
    repeat (2 * FR) step();
    bus.digits = 24'h000000;
    repeat (FR + FR / 2) step();
    bus.digits = 24'h999999;
    repeat (2 * FR) step();
    for (int k = 0; k < 2 * FR && (t % FR) != FR - 1; k++) step();
    bus.digits = 24'h99999A;
    bus.dp_mask = 6'b000001;
    repeat (2 * FR) step();
    for (int k = 0; k < 2 * FR && (t / DIV) % 6 != 3; k++) step();
    step();
    bus.en = 1'b0;
    repeat (10) step();
    bus.en = 1'b1;
    repeat (FR + 3) step();
    for (int k = 0; k < 2 * FR && (t % FR) != 0; k++) step();
    chk("tick_before_async", 32'(bus.frame_tick), 32'h1);
    #2 rst_n = 1'b0;
    #1 reset_check("async");
    @(negedge clk);
    reset_check("async_hold");
    rst_n = 1'b1;
    model_reset();
    repeat (FR + 4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
